// File: rtl/charge_pkg.sv
// Shared definitions for the charging-session controller.
// Holds the FSM state encoding, the BCD field positions inside PresentTime,
// the parameter defaults, and a saturating credit increment helper.
package charge_pkg;

    // Session FSM state encoding
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PAID     = 3'd1,
        CHARGING = 3'd2,
        PAUSED   = 3'd3,
        DONE     = 3'd4
    } chargeState_t;

    // PresentTime layout: BCD M:SS
    localparam int unsigned TIME_W   = 12;
    localparam int unsigned BCD_W    = 4;
    localparam int unsigned MIN_MSB  = 11;
    localparam int unsigned MIN_LSB  = 8;
    localparam int unsigned TENS_MSB = 7;
    localparam int unsigned TENS_LSB = 4;
    localparam int unsigned SECS_MSB = 3;
    localparam int unsigned SECS_LSB = 0;

    // Parameter defaults
    localparam logic [BCD_W-1:0] MAX_CREDIT_DEFAULT = 4'd9;
    localparam logic [BCD_W-1:0] STEP_DEFAULT       = 4'd1;

    // Add one minute of credit, holding at the limit instead of wrapping
    function automatic logic [BCD_W-1:0] satInc(input logic [BCD_W-1:0] value,
                                                input logic [BCD_W-1:0] limit);
        return (value >= limit) ? limit : value + 4'd1;
    endfunction

endpackage

// File: rtl/pause_timer.sv
// Pause timer: clear/enable up-counter with a registered terminal-count flag.
// Ports:
//   Clk     - clock
//   Reset   - synchronous active-high reset
//   Clear   - forces the count to 0 (has priority over Enable)
//   Enable  - increments the count by one per cycle
//   Expired - high while the count equals TIMEOUT-1
module pause_timer #(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Clear,
    input  logic Enable,
    output logic Expired
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] countNext;

    // Next count
    always_comb begin
        countNext = count;
        if (Clear) begin
            countNext = '0;
        end else if (Enable) begin
            countNext = count + CNT_W'(1);
        end
    end

    // Count register; the flag is computed from the next count so it is
    // aligned with the count it describes
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count   <= '0;
            Expired <= 1'b0;
        end else begin
            count   <= countNext;
            Expired <= (countNext == LAST);
        end
    end

endmodule

// File: rtl/charge_session_ctrl.sv
// Charging-station session controller, upstream of the station time counter.
// Takes coin credit in whole minutes, starts/pauses/ends charging on plug and
// button events, and ends the session when elapsed minutes reach the credit.
// Ports:
//   Clk, Reset            - clock, synchronous active-high reset
//   CoinIn                - pulse, +1 minute of credit
//   PlugIn                - level, vehicle connected
//   StartBtn, StopBtn     - pulses, start/resume and abort/end
//   PresentTime[11:0]     - counter elapsed time, BCD M:SS
//   CounterEnable         - counter count enable
//   CounterInput[3:0]     - counter step value
//   CounterClear          - pulse, restart the counter at 0:00
//   Credit[3:0]           - purchased minutes
//   Charging, Done        - session status
//   Refund                - pulse on abort before charging started
module charge_session_ctrl
    import charge_pkg::*;
#(
    parameter logic [3:0]  MAX_CREDIT    = MAX_CREDIT_DEFAULT,
    parameter logic [3:0]  STEP          = STEP_DEFAULT,
    parameter int unsigned PAUSE_TIMEOUT = 1000
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              CoinIn,
    input  logic              PlugIn,
    input  logic              StartBtn,
    input  logic              StopBtn,
    input  logic [TIME_W-1:0] PresentTime,
    output logic              CounterEnable,
    output logic [BCD_W-1:0]  CounterInput,
    output logic              CounterClear,
    output logic [BCD_W-1:0]  Credit,
    output logic              Charging,
    output logic              Done,
    output logic              Refund
);

    chargeState_t     state;
    chargeState_t     stateNext;
    logic [BCD_W-1:0] creditNext;
    logic             clearNext;
    logic             refundNext;
    logic             completeNow;
    logic             timerExpired;
    logic             unusedTimeLow;

    // Only the minutes digit is compared; the lower digits are not needed
    assign unusedTimeLow = ^PresentTime[TENS_MSB:SECS_LSB];

    // PresentTime is stale while the counter restart is in flight
    assign completeNow = (PresentTime[MIN_MSB:MIN_LSB] >= Credit) && !CounterClear;

    // Pause timer runs only while paused and is zeroed everywhere else
    pause_timer #(
        .TIMEOUT (PAUSE_TIMEOUT)
    ) u_pauseTimer (
        .Clk     (Clk),
        .Reset   (Reset),
        .Clear   (state != PAUSED),
        .Enable  (state == PAUSED),
        .Expired (timerExpired)
    );

    // Next-state, credit and pulse decisions
    always_comb begin
        stateNext  = state;
        creditNext = Credit;
        clearNext  = 1'b0;
        refundNext = 1'b0;

        case (state)
            IDLE: begin
                if (CoinIn) begin
                    creditNext = 4'd1;
                    stateNext  = PAID;
                end
            end

            PAID: begin
                if (StopBtn) begin
                    refundNext = 1'b1;
                    creditNext = '0;
                    stateNext  = IDLE;
                end else begin
                    if (StartBtn && PlugIn) begin
                        stateNext = CHARGING;
                        clearNext = 1'b1;
                    end
                    if (CoinIn) begin
                        creditNext = satInc(Credit, MAX_CREDIT);
                    end
                end
            end

            CHARGING: begin
                if (StopBtn) begin
                    stateNext = DONE;
                end else if (!PlugIn) begin
                    stateNext = PAUSED;
                end else if (completeNow) begin
                    stateNext = DONE;
                end
                if (CoinIn) begin
                    creditNext = satInc(Credit, MAX_CREDIT);
                end
            end

            PAUSED: begin
                if (StopBtn) begin
                    stateNext = DONE;
                end else if (timerExpired) begin
                    stateNext = DONE;
                end else if (StartBtn && PlugIn) begin
                    stateNext = CHARGING;
                end
                if (CoinIn) begin
                    creditNext = satInc(Credit, MAX_CREDIT);
                end
            end

            DONE: begin
                if (!PlugIn) begin
                    creditNext = '0;
                    stateNext  = IDLE;
                end
            end

            default: begin
                creditNext = '0;
                stateNext  = IDLE;
            end
        endcase
    end

    // State and registered outputs, all derived from the next state
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= IDLE;
            Credit        <= '0;
            CounterClear  <= 1'b0;
            Refund        <= 1'b0;
            CounterEnable <= 1'b0;
            CounterInput  <= '0;
            Charging      <= 1'b0;
            Done          <= 1'b0;
        end else begin
            state         <= stateNext;
            Credit        <= creditNext;
            CounterClear  <= clearNext;
            Refund        <= refundNext;
            CounterEnable <= (stateNext == CHARGING);
            CounterInput  <= (stateNext == CHARGING) ? STEP : 4'd0;
            Charging      <= (stateNext == CHARGING);
            Done          <= (stateNext == DONE);
        end
    end

endmodule

// File: tb/tb_charge_session_ctrl.sv
// Directed, table-driven bench for charge_session_ctrl, plus hand-written
// sequences for pause/resume and the pause timeout.
module tb_charge_session_ctrl;

    localparam logic [3:0] TB_STEP    = 4'd1;
    localparam int         TB_TIMEOUT = 20;

    logic        Clk;
    logic        Reset;
    logic        CoinIn;
    logic        PlugIn;
    logic        StartBtn;
    logic        StopBtn;
    logic [11:0] PresentTime;
    logic        CounterEnable;
    logic [3:0]  CounterInput;
    logic        CounterClear;
    logic [3:0]  Credit;
    logic        Charging;
    logic        Done;
    logic        Refund;

    int passCount  = 0;
    int checkCount = 0;

    charge_session_ctrl #(
        .MAX_CREDIT    (4'd9),
        .STEP          (TB_STEP),
        .PAUSE_TIMEOUT (TB_TIMEOUT)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .CoinIn        (CoinIn),
        .PlugIn        (PlugIn),
        .StartBtn      (StartBtn),
        .StopBtn       (StopBtn),
        .PresentTime   (PresentTime),
        .CounterEnable (CounterEnable),
        .CounterInput  (CounterInput),
        .CounterClear  (CounterClear),
        .Credit        (Credit),
        .Charging      (Charging),
        .Done          (Done),
        .Refund        (Refund)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst;
        logic        coin;
        logic        plug;
        logic        start;
        logic        stop;
        logic [11:0] pt;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Expected output word: {en, in[3:0], clr, credit[3:0], chg, done, refund}
    function automatic logic [12:0] expWord(input logic en, input logic clr,
                                            input logic [3:0] cr, input logic chg,
                                            input logic dn, input logic rf);
        return {en, (en ? TB_STEP : 4'd0), clr, cr, chg, dn, rf};
    endfunction

    task automatic addVec(input logic r, input logic c, input logic p,
                          input logic s, input logic t, input logic [11:0] pt,
                          input logic en, input logic clr, input logic [3:0] cr,
                          input logic chg, input logic dn, input logic rf);
        vec_t v;
        v.rst = r; v.coin = c; v.plug = p; v.start = s; v.stop = t; v.pt = pt;
        v.exp = expWord(en, clr, cr, chg, dn, rf);
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic c, input logic p,
                         input logic s, input logic t, input logic [11:0] pt);
        Reset = r; CoinIn = c; PlugIn = p; StartBtn = s; StopBtn = t; PresentTime = pt;
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOut(input string name, input logic [12:0] exp);
        logic [12:0] act;
        act = {CounterEnable, CounterInput, CounterClear, Credit, Charging, Done, Refund};
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("FAIL %s: got %013b want %013b (en,in[3:0],clr,credit[3:0],chg,done,refund)",
                     name, act, exp);
        end
    endtask

    initial begin
        int cycles;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);

        // Power-on reset, ignored buttons in IDLE, basic credit, charge to completion
        addVec(1,0,0,0,0,12'h000, 0,0,4'd0,0,0,0);
        addVec(1,0,0,0,0,12'h000, 0,0,4'd0,0,0,0);
        addVec(0,0,0,1,0,12'h000, 0,0,4'd0,0,0,0);
        addVec(0,0,0,0,1,12'h000, 0,0,4'd0,0,0,0);
        addVec(0,1,0,0,0,12'h000, 0,0,4'd1,0,0,0);
        addVec(0,1,0,0,0,12'h000, 0,0,4'd2,0,0,0);
        addVec(0,1,0,0,0,12'h000, 0,0,4'd3,0,0,0);
        addVec(0,0,0,1,0,12'h000, 0,0,4'd3,0,0,0);   // start unplugged: ignored
        addVec(0,0,1,1,0,12'h000, 1,1,4'd3,1,0,0);   // start: clear pulse + enable
        addVec(0,0,1,0,0,12'h512, 1,0,4'd3,1,0,0);   // stale time masked during clear
        addVec(0,0,1,0,0,12'h259, 1,0,4'd3,1,0,0);
        addVec(0,0,1,0,0,12'h300, 0,0,4'd3,0,1,0);   // 3 minutes reached
        addVec(0,1,1,0,0,12'h300, 0,0,4'd3,0,1,0);   // coin ignored in DONE
        addVec(0,0,0,0,0,12'h300, 0,0,4'd0,0,0,0);   // unplug: back to IDLE
        // Reset in the middle of a session
        addVec(0,1,0,0,0,12'h000, 0,0,4'd1,0,0,0);
        addVec(0,1,0,0,0,12'h000, 0,0,4'd2,0,0,0);
        addVec(0,0,1,1,0,12'h000, 1,1,4'd2,1,0,0);
        addVec(0,0,1,0,0,12'h000, 1,0,4'd2,1,0,0);
        addVec(1,1,1,0,0,12'h000, 0,0,4'd0,0,0,0);
        addVec(1,0,1,0,0,12'h000, 0,0,4'd0,0,0,0);
        addVec(0,1,0,0,0,12'h000, 0,0,4'd1,0,0,0);
        // Twelve coins in total: saturate at 9, then refund
        for (int k = 2; k <= 12; k++) begin
            addVec(0,1,0,0,0,12'h000, 0,0,(k > 9) ? 4'd9 : 4'(k),0,0,0);
        end
        addVec(0,0,0,0,1,12'h000, 0,0,4'd0,0,0,1);
        addVec(0,0,0,0,0,12'h000, 0,0,4'd0,0,0,0);
        // Stop together with a completion-level time in CHARGING
        addVec(0,1,0,0,0,12'h000, 0,0,4'd1,0,0,0);
        addVec(0,1,0,0,0,12'h000, 0,0,4'd2,0,0,0);
        addVec(0,0,1,1,0,12'h000, 1,1,4'd2,1,0,0);
        addVec(0,0,1,0,0,12'h000, 1,0,4'd2,1,0,0);
        addVec(0,0,1,0,1,12'h200, 0,0,4'd2,0,1,0);
        addVec(0,1,1,0,0,12'h200, 0,0,4'd2,0,1,0);
        addVec(0,0,0,0,0,12'h000, 0,0,4'd0,0,0,0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].coin, vecs[i].plug, vecs[i].start,
                  vecs[i].stop, vecs[i].pt);
            step();
            checkOut($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Pause on unplug, then resume without a counter clear
        drive(0,1,0,0,0,12'h000); step();
        drive(0,1,0,0,0,12'h000); step();
        drive(0,0,1,1,0,12'h000); step();
        checkOut("t4 start", expWord(1,1,4'd2,1,0,0));
        drive(0,0,1,0,0,12'h045); step();
        drive(0,0,0,0,0,12'h045); step();
        checkOut("t4 paused", expWord(0,0,4'd2,0,0,0));
        for (int k = 0; k < 3; k++) step();
        checkOut("t4 still paused", expWord(0,0,4'd2,0,0,0));
        drive(0,0,1,1,0,12'h045); step();
        checkOut("t4 resume", expWord(1,0,4'd2,1,0,0));
        drive(0,0,1,0,0,12'h045); step();
        checkOut("t4 charging", expWord(1,0,4'd2,1,0,0));

        // Pause timeout: DONE exactly TB_TIMEOUT cycles after entering PAUSED
        drive(0,0,0,0,0,12'h045); step();
        checkOut("t5 paused", expWord(0,0,4'd2,0,0,0));
        cycles = 0;
        for (int k = 1; k <= 2 * TB_TIMEOUT; k++) begin
            step();
            cycles = k;
            if (Done) break;
        end
        checkCount++;
        if (cycles == TB_TIMEOUT && Done) begin
            passCount++;
        end else begin
            $display("FAIL t5 timeout: done=%0b after %0d cycles, want done=1 after %0d",
                     Done, cycles, TB_TIMEOUT);
        end
        checkOut("t5 done", expWord(0,0,4'd2,0,1,0));
        step();
        checkOut("t5 idle", expWord(0,0,4'd0,0,0,0));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/charge_session_ctrl.md
Name: charge_session_ctrl

Overview:
Charging-station session controller that sits directly upstream of the station time counter. It drives the counter's enable, step and clear inputs, and consumes the counter's BCD M:SS PresentTime output. It accepts coin credit in whole minutes, starts, pauses and stops charging on plug and button events, and declares the session done when elapsed minutes reach the purchased credit.

Parameters:
MAX_CREDIT, 4'd9, saturation limit for purchased minutes (BCD digit, 1..9).
STEP, 4'd1, value driven on CounterInput while counting.
PAUSE_TIMEOUT, 1000, Clk cycles allowed in PAUSED before the session is forced to DONE.

Ports:
Clk  in  1  system clock; all state changes on the rising edge.
Reset  in  1  synchronous, active-high reset.
CoinIn  in  1  single-cycle pulse; adds one minute of credit.
PlugIn  in  1  level; 1 = vehicle connected.
StartBtn  in  1  single-cycle pulse; start or resume charging.
StopBtn  in  1  single-cycle pulse; abort (refund if not started) or end session.
PresentTime  in  12  elapsed time from the counter, BCD: [11:8] minutes, [7:4] tens of seconds, [3:0] seconds.
CounterEnable  out  1  counter count enable.
CounterInput  out  4  counter step value.
CounterClear  out  1  one-cycle pulse; top level uses it to restart the counter at 0:00.
Credit  out  4  purchased minutes, BCD 0..MAX_CREDIT.
Charging  out  1  high in CHARGING.
Done  out  1  high in DONE.
Refund  out  1  one-cycle pulse on StopBtn from PAID.

Behaviour:
- Reset: the controller is in IDLE, and every output is 0, including CounterInput and Credit. The pause timer is cleared. Reset mid-session aborts immediately, with no Refund pulse.
- All outputs are registered. Every decision is visible one cycle after the inputs that cause it.
- States are IDLE, PAID, CHARGING, PAUSED and DONE.
- IDLE:
  - CoinIn: Credit = 1, go to PAID.
  - StartBtn and StopBtn are ignored.
- PAID:
  - CoinIn: Credit + 1, saturating at MAX_CREDIT.
  - StopBtn: Refund pulse, Credit = 0, go to IDLE.
  - StartBtn with PlugIn = 1: go to CHARGING and pulse CounterClear for 1 cycle. CounterEnable = 1 and CounterInput = STEP from that same edge.
  - StartBtn with PlugIn = 0: ignored.
- CHARGING:
  - Outputs: CounterEnable = 1, Charging = 1.
  - CoinIn extends Credit, saturating at MAX_CREDIT.
  - Completion condition: PresentTime[11:8] >= Credit. It is masked in the cycle where CounterClear is high, because PresentTime is stale then.
  - When the condition holds: go to DONE and drop CounterEnable. The counter may advance at most one further step.
  - PlugIn = 0: go to PAUSED, CounterEnable = 0, pause timer starts at 0.
- PAUSED:
  - CounterEnable = 0, and PresentTime is held by the counter.
  - StartBtn with PlugIn = 1: return to CHARGING, with no CounterClear.
  - The pause timer increments every cycle. When it reaches PAUSE_TIMEOUT - 1, go to DONE.
  - CoinIn is accepted, saturating at MAX_CREDIT.
- DONE:
  - Done = 1, CounterEnable = 0, CoinIn ignored.
  - PlugIn = 0: Credit = 0, go to IDLE.
  - If PlugIn is already 0 on entry, leave after 1 cycle in DONE.
- Same-cycle priority, highest first: Reset, StopBtn, PlugIn fall, completion or timeout, StartBtn, CoinIn.
  - StopBtn in CHARGING or PAUSED goes to DONE, with no refund.
  - A coin arriving in the same cycle as a transition is still added if the state it arrives in accepts coins.
- Credit never exceeds MAX_CREDIT and never wraps. PresentTime is only compared, never modified.

Decomposition:
- Package charge_pkg holds:
  - the state encoding (IDLE = 0, PAID = 1, CHARGING = 2, PAUSED = 3, DONE = 4, 3 bits);
  - the BCD field slice constants for PresentTime;
  - the defaults for MAX_CREDIT and STEP.
- One sub-module, pause_timer: a clear/enable counter with a terminal-count flag, sized as clog2(PAUSE_TIMEOUT). The FSM and credit logic stay in charge_session_ctrl.

Test Plan:
1. Reset asserted for 2 cycles in the middle of a session -> all outputs 0, state IDLE. A following CoinIn gives Credit = 1.
2. Three CoinIn pulses, PlugIn = 1, StartBtn -> Credit = 3, one CounterClear pulse, CounterEnable = 1. The bench drives PresentTime 12'h259 then 12'h300 -> Done rises within 1 cycle of 12'h300 and CounterEnable falls.
3. Twelve CoinIn pulses -> Credit saturates at 9. StopBtn in PAID -> one Refund pulse, Credit = 0, IDLE.
4. In CHARGING, drop PlugIn at PresentTime 12'h045 -> PAUSED, CounterEnable = 0. Raise PlugIn and pulse StartBtn -> CHARGING with no CounterClear.
5. In PAUSED with PAUSE_TIMEOUT = 20, no StartBtn -> DONE exactly 20 cycles after entering PAUSED. Drop PlugIn -> IDLE, Credit = 0.
6. StopBtn and a completion-level PresentTime in the same cycle in CHARGING -> DONE (StopBtn wins, same result), no Refund. CoinIn in DONE is ignored.
